// File: rtl/univ_shift_reg_if.sv
// Bus bundle for univ_shift_reg: control/data inputs and registered outputs.
// The master modport drives mode/data; the slave modport is the register itself.
interface univ_shift_reg_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    logic [1:0]       mode;
    logic             serial_in;
    logic             rotate;
    logic [WIDTH-1:0] par_in;
    logic [WIDTH-1:0] Q;
    logic             serial_out_r;
    logic             serial_out_l;
    logic [CntW-1:0]  shift_cnt;
    logic             word_valid;

    modport master (
        output mode, serial_in, rotate, par_in,
        input  Q, serial_out_r, serial_out_l, shift_cnt, word_valid
    );

    modport slave (
        input  mode, serial_in, rotate, par_in,
        output Q, serial_out_r, serial_out_l, shift_cnt, word_valid
    );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold / shift right / shift left / parallel load, with a
// shift counter that pulses word_valid after every WIDTH-th shift.
// Optional feature macro: UNISHIFT_ROTATE_EN (rotate input selects the leaving bit
// as the shifted-in bit). Without it the rotate input is ignored.
module univ_shift_reg #(
    parameter int unsigned     WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic               clk,
    input logic               clr,
    univ_shift_reg_if.slave   bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             wv_q, wv_d;
    logic             sin_r, sin_l;

`ifdef UNISHIFT_ROTATE_EN
    // Rotate feeds the bit leaving the register back into the opposite end.
    assign sin_r = bus.rotate ? q_q[0]       : bus.serial_in;
    assign sin_l = bus.rotate ? q_q[WIDTH-1] : bus.serial_in;
`else
    logic unused_rotate;
    assign unused_rotate = bus.rotate;
    assign sin_r = bus.serial_in;
    assign sin_l = bus.serial_in;
`endif

    // Next-state decode for data register, shift counter and word pulse.
    always_comb begin
        q_d   = q_q;
        cnt_d = cnt_q;
        wv_d  = 1'b0;
        unique case (bus.mode)
            2'b00: begin
                q_d = q_q;
            end
            2'b01: begin
                q_d = {sin_r, q_q[WIDTH-1:1]};
            end
            2'b10: begin
                q_d = {q_q[WIDTH-2:0], sin_l};
            end
            2'b11: begin
                q_d   = bus.par_in;
                cnt_d = '0;
            end
        endcase
        // Both shift directions count alike; wrap flags a completed word.
        if (bus.mode == 2'b01 || bus.mode == 2'b10) begin
            if (cnt_q == CntW'(WIDTH - 1)) begin
                cnt_d = '0;
                wv_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    // State registers with synchronous clear taking priority over every mode.
    always_ff @(posedge clk) begin
        if (clr) begin
            q_q   <= RESET_VAL;
            cnt_q <= '0;
            wv_q  <= 1'b0;
        end else begin
            q_q   <= q_d;
            cnt_q <= cnt_d;
            wv_q  <= wv_d;
        end
    end

    assign bus.Q            = q_q;
    assign bus.serial_out_r = q_q[0];
    assign bus.serial_out_l = q_q[WIDTH-1];
    assign bus.shift_cnt    = cnt_q;
    assign bus.word_valid   = wv_q;
endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=4). A second instance with
// RESET_VAL=4'hA shares the stimulus. Expected values come from an arithmetic model.
module tb_univ_shift_reg;
    localparam int W    = 4;
    localparam int Mask = (1 << W) - 1;
`ifdef UNISHIFT_ROTATE_EN
    localparam bit RotEn = 1'b1;
`else
    localparam bit RotEn = 1'b0;
`endif

    logic clk;
    logic clr;

    univ_shift_reg_if #(.WIDTH(W)) bus ();
    univ_shift_reg_if #(.WIDTH(W)) bus_a ();

    univ_shift_reg #(.WIDTH(W), .RESET_VAL(4'h0)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    univ_shift_reg #(.WIDTH(W), .RESET_VAL(4'hA)) dut_a (
        .clk (clk),
        .clr (clr),
        .bus (bus_a)
    );

    assign bus_a.mode      = bus.mode;
    assign bus_a.serial_in = bus.serial_in;
    assign bus_a.rotate    = bus.rotate;
    assign bus_a.par_in    = bus.par_in;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: plain integers, one copy per reset value.
    int m_q  = 0;
    int m_qa = 0;
    int m_cnt = 0;
    int m_wv  = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int next_q(input int q, input int m, input int s, input int r,
                                  input int p);
        int b;
        case (m)
            1: begin
                b = (RotEn && r != 0) ? (q & 1) : s;
                return (q >> 1) | (b << (W - 1));
            end
            2: begin
                b = (RotEn && r != 0) ? ((q >> (W - 1)) & 1) : s;
                return ((q << 1) | b) & Mask;
            end
            3: return p & Mask;
            default: return q;
        endcase
    endfunction

    task automatic step(input int c, input int m, input int s, input int r, input int p);
        clr           = c[0];
        bus.mode      = m[1:0];
        bus.serial_in = s[0];
        bus.rotate    = r[0];
        bus.par_in    = p[W-1:0];
        @(posedge clk);
        if (c != 0) begin
            m_q = 0; m_qa = 'hA; m_cnt = 0; m_wv = 0;
        end else begin
            m_q  = next_q(m_q, m, s, r, p);
            m_qa = next_q(m_qa, m, s, r, p);
            if (m == 1 || m == 2) begin
                if (m_cnt == W - 1) begin
                    m_cnt = 0; m_wv = 1;
                end else begin
                    m_cnt++; m_wv = 0;
                end
            end else begin
                if (m == 3) m_cnt = 0;
                m_wv = 0;
            end
        end
        #1;
        check_val("q",      int'(bus.Q), m_q);
        check_val("q_a",    int'(bus_a.Q), m_qa);
        check_val("sout_r", int'(bus.serial_out_r), m_q & 1);
        check_val("sout_l", int'(bus.serial_out_l), (m_q >> (W - 1)) & 1);
        check_val("cnt",    int'(bus.shift_cnt), m_cnt);
        check_val("wv",     int'(bus.word_valid), m_wv);
        check_val("wv_a",   int'(bus_a.word_valid), m_wv);
    endtask

    initial begin
        clr = 1'b1; bus.mode = 2'b00; bus.serial_in = 1'b0; bus.rotate = 1'b0;
        bus.par_in = '0;

        // Reset with arbitrary inputs present.
        step(1, 3, 1, 1, 'hF);
        check_val("rst_q",   int'(bus.Q), 0);
        check_val("rst_q_a", int'(bus_a.Q), 'hA);

        // Serial-in right shift 1,0,1,1.
        step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        check_val("sipo_q",  int'(bus.Q), 'b1101);
        check_val("sipo_wv", int'(bus.word_valid), 1);
        step(0, 0, 0, 0, 0);
        check_val("hold_wv", int'(bus.word_valid), 0);

        // Load then left/right single shifts.
        step(0, 3, 0, 0, 'b1001);
        step(0, 2, 0, 0, 0);
        check_val("left_q",  int'(bus.Q), 'b0010);
        check_val("left_sl", int'(bus.serial_out_l), 0);
        step(0, 1, 1, 0, 0);
        check_val("right_q", int'(bus.Q), 'b1001);

        // Partial word discarded by load.
        step(0, 1, 0, 0, 0);
        step(0, 2, 1, 0, 0);
        step(0, 3, 0, 0, 'b0110);
        for (int i = 0; i < 4; i++) step(0, 1 + (i & 1), i & 1, 0, 0);

        // Continuous shifting, then shifts interleaved with holds.
        for (int i = 0; i < 12; i++) step(0, 1, i & 1, 0, 0);
        for (int i = 0; i < 10; i++) step(0, (i % 3 == 0) ? 0 : 1, 1, 0, 0);

        // Clear while the counter sits at WIDTH-1.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);
        check_val("pre_clr_cnt", int'(bus.shift_cnt), 3);
        step(1, 1, 1, 0, 0);
        check_val("clr_win_q",  int'(bus.Q), 0);
        check_val("clr_win_wv", int'(bus.word_valid), 0);

        // Rotation (or plain zero fill without the feature).
        step(0, 3, 0, 0, 'b1000);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 0);
        check_val("rot_q",  int'(bus.Q), RotEn ? 'b1000 : 'b0000);
        check_val("rot_wv", int'(bus.word_valid), 1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 19) == 0) ? 1 : 0, int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, Mask)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
